// File: rtl/channel_cfg_seq.sv
// channel_cfg_seq
//   Configuration sequencer for the PWL channel model. The host writes tap
//   coefficients into a shadow bank. A commit copies the shadow bank into the
//   active bank (tap_bus), but only after ch_busy has been low for GUARD
//   consecutive cycles. This keeps a tap update from landing in the middle of
//   a channel transition.
//
//   Optional feature macro: CH_CFG_READBACK_EN adds a registered read port
//   (rd_addr/rd_data) onto the active bank.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   wr_valid/ready  host tap write handshake (wr_addr, wr_data)
//   commit, abort   request / cancel the shadow->active swap
//   ch_busy         channel stimulus in flight; restarts the quiet count
//   tap_bus         active bank, tap i at [i*TAPW +: TAPW]
//   upd             one-cycle pulse when tap_bus changes
//   state           FSM state (IDLE=0 DIRTY=1 WAIT=2 SWAP=3)
//   err, err_clr    sticky bad-address flag and its clear
//   rd_addr/rd_data active-bank readback, 1-cycle latency (CH_CFG_READBACK_EN)
module channel_cfg_seq #(
  parameter int NTAP  = 8,
  parameter int TAPW  = 12,
  parameter int GUARD = 16,
  parameter int AW    = $clog2(NTAP)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [TAPW-1:0]      wr_data,
  input  logic                 commit,
  input  logic                 abort,
  input  logic                 ch_busy,
  output logic [NTAP*TAPW-1:0] tap_bus,
  output logic                 upd,
  output logic [1:0]           state,
  input  logic                 err_clr,
`ifdef CH_CFG_READBACK_EN
  input  logic [AW-1:0]        rd_addr,
  output logic [TAPW-1:0]      rd_data,
`endif
  output logic                 err
);

  localparam int CW = (GUARD < 2) ? 1 : $clog2(GUARD);
  localparam logic [TAPW-1:0] TAP_ONE = TAPW'(1 << (TAPW-2));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIRTY = 2'd1,
    WAIT  = 2'd2,
    SWAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TAPW-1:0] active_q [NTAP];
  logic [TAPW-1:0] active_d [NTAP];
  logic [TAPW-1:0] shadow_q [NTAP];
  logic [TAPW-1:0] shadow_d [NTAP];
  logic            upd_q, upd_d;
  logic            err_q, err_d;
  logic            wr_fire;
  logic            addr_ok;

  assign wr_ready = (state_q == IDLE) || (state_q == DIRTY);
  assign wr_fire  = wr_valid && wr_ready;
  assign upd      = upd_q;
  assign err      = err_q;
  assign state    = state_q;

  always_comb begin
    tap_bus = '0;
    for (int unsigned i = 0; i < NTAP; i++) begin
      tap_bus[i*TAPW +: TAPW] = active_q[i];
    end
  end

  // The address range check is done by matching each valid index. This also
  // works when NTAP is not a power of two.
  always_comb begin
    addr_ok = 1'b0;
    for (int unsigned i = 0; i < NTAP; i++) begin
      if (wr_addr == AW'(i)) addr_ok = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    upd_d    = 1'b0;
    err_d    = err_q;

    if (wr_fire) begin
      for (int unsigned i = 0; i < NTAP; i++) begin
        if (wr_addr == AW'(i)) shadow_d[i] = wr_data;
      end
    end

    // A set on the same edge as a clear wins.
    if (err_clr) err_d = 1'b0;
    if (wr_fire && !addr_ok) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (wr_fire) begin
          if (commit) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            state_d = DIRTY;
          end
        end
      end
      DIRTY: begin
        if (commit) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = DIRTY;
        end else if (ch_busy) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(GUARD-1)) begin
          state_d = SWAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SWAP: begin
        active_d = shadow_q;
        upd_d    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NTAP; i++) begin
        active_q[i] <= (i == 0) ? TAP_ONE : '0;
        shadow_q[i] <= (i == 0) ? TAP_ONE : '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef CH_CFG_READBACK_EN
  logic [TAPW-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int unsigned i = 0; i < NTAP; i++) begin
      if (rd_addr == AW'(i)) rd_data_d = active_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`else
  // No readback port in this build.
`endif

endmodule

// File: tb/tb_channel_cfg_seq.sv
// tb_channel_cfg_seq
//   Directed bench for channel_cfg_seq. The main instance uses the default
//   sizes (NTAP=8, TAPW=12, GUARD=16). With NTAP=8 a 3-bit address cannot
//   express an out-of-range index. A second instance with NTAP=6 covers the
//   bad-address cases (addresses 6 and 7).
module tb_channel_cfg_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        wr_valid, wr_ready, commit, abort, ch_busy, upd, err, err_clr;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic [95:0] tap_bus;
  logic [1:0]  state;

  logic        s_wr_valid, s_wr_ready, s_commit, s_abort, s_ch_busy, s_upd, s_err, s_err_clr;
  logic [2:0]  s_wr_addr;
  logic [11:0] s_wr_data;
  logic [71:0] s_tap_bus;
  logic [1:0]  s_state;

`ifdef CH_CFG_READBACK_EN
  logic [2:0]  rd_addr, s_rd_addr;
  logic [11:0] rd_data, s_rd_data;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  channel_cfg_seq #(.NTAP(8), .TAPW(12), .GUARD(16)) u_dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .abort(abort),
    .ch_busy(ch_busy), .tap_bus(tap_bus), .upd(upd), .state(state),
    .err_clr(err_clr),
`ifdef CH_CFG_READBACK_EN
    .rd_addr(rd_addr), .rd_data(rd_data),
`endif
    .err(err)
  );

  channel_cfg_seq #(.NTAP(6), .TAPW(12), .GUARD(16)) u_dut6 (
    .clk(clk), .rst(rst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .commit(s_commit), .abort(s_abort),
    .ch_busy(s_ch_busy), .tap_bus(s_tap_bus), .upd(s_upd), .state(s_state),
    .err_clr(s_err_clr),
`ifdef CH_CFG_READBACK_EN
    .rd_addr(s_rd_addr), .rd_data(s_rd_data),
`endif
    .err(s_err)
  );

  function automatic logic [11:0] tap_of(input logic [95:0] bus, input int i);
    return bus[i*12 +: 12];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until upd is seen (0 if not seen in 40).
  task automatic wait_upd(input bit six, output int k);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (k == 0 && (six ? s_upd : upd)) k = i;
      if (k != 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 0; wr_addr = '0; wr_data = '0; commit = 0; abort = 0; ch_busy = 0; err_clr = 0;
    s_wr_valid = 0; s_wr_addr = '0; s_wr_data = '0; s_commit = 0; s_abort = 0; s_ch_busy = 0; s_err_clr = 0;
`ifdef CH_CFG_READBACK_EN
    rd_addr = '0; s_rd_addr = '0;
`endif
    tick(); tick();
    rst = 1'b0;
    n_total++; if (tap_bus !== 96'h400) $display("FAIL reset_taps got=%h exp=%h", tap_bus, 96'h400); else n_pass++;
    n_total++; if (upd !== 1'b0) $display("FAIL reset_upd got=%b exp=0", upd); else n_pass++;
    n_total++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else n_pass++;
    n_total++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    n_total++; if (s_tap_bus !== 72'h400) $display("FAIL reset_taps6 got=%h exp=%h", s_tap_bus, 72'h400); else n_pass++;
`ifdef CH_CFG_READBACK_EN
    n_total++; if (rd_data !== 12'h000) $display("FAIL reset_rd_data got=%h exp=000", rd_data); else n_pass++;
`endif
    // A commit with no write in IDLE is ignored.
    commit = 1; tick(); commit = 0;
    n_total++; if (state !== 2'd0) $display("FAIL idle_commit_state got=%0d exp=0", state); else n_pass++;
    tick();
    n_total++; if (upd !== 1'b0) $display("FAIL idle_commit_upd got=%b exp=0", upd); else n_pass++;
  endtask

  task automatic test_commit_latency();
    logic [95:0] exp;
    int k;
    wr_valid = 1; wr_addr = 3'd1; wr_data = 12'h0F0; tick();
    n_total++; if (state !== 2'd1) $display("FAIL write_dirty got=%0d exp=1", state); else n_pass++;
    wr_addr = 3'd2; wr_data = 12'hFE0; tick();
    wr_valid = 0; commit = 1; tick(); commit = 0;
    n_total++; if (state !== 2'd2) $display("FAIL commit_wait got=%0d exp=2", state); else n_pass++;
    n_total++; if (wr_ready !== 1'b0) $display("FAIL wait_wr_ready got=%b exp=0", wr_ready); else n_pass++;
    wait_upd(1'b0, k);
    n_total++; if (k !== 17) $display("FAIL commit_latency got=%0d exp=17", k); else n_pass++;
    exp = 96'h400; exp[23:12] = 12'h0F0; exp[35:24] = 12'hFE0;
    n_total++; if (tap_bus !== exp) $display("FAIL swap_taps got=%h exp=%h", tap_bus, exp); else n_pass++;
    n_total++; if (state !== 2'd0) $display("FAIL swap_idle got=%0d exp=0", state); else n_pass++;
    tick();
    n_total++; if (upd !== 1'b0) $display("FAIL upd_one_cycle got=%b exp=0", upd); else n_pass++;
  endtask

`ifdef CH_CFG_READBACK_EN
  task automatic test_readback();
    rd_addr = 3'd1; tick();
    n_total++; if (rd_data !== 12'h0F0) $display("FAIL rd_tap1 got=%h exp=0F0", rd_data); else n_pass++;
    rd_addr = 3'd2; tick();
    n_total++; if (rd_data !== 12'hFE0) $display("FAIL rd_tap2 got=%h exp=FE0", rd_data); else n_pass++;
    s_rd_addr = 3'd0; tick();
    n_total++; if (s_rd_data !== 12'h400) $display("FAIL rd6_tap0 got=%h exp=400", s_rd_data); else n_pass++;
    s_rd_addr = 3'd6; tick();
    n_total++; if (s_rd_data !== 12'h000) $display("FAIL rd6_oob got=%h exp=000", s_rd_data); else n_pass++;
  endtask
`endif

  task automatic test_busy_restart();
    int k;
    int uc;
    // Write + commit on the same edge goes straight to WAIT.
    wr_valid = 1; wr_addr = 3'd3; wr_data = 12'h123; commit = 1; tick();
    wr_valid = 0; commit = 0;
    n_total++; if (state !== 2'd2) $display("FAIL wc_same_edge got=%0d exp=2", state); else n_pass++;
    uc = 0;
    for (int i = 0; i < 10; i++) begin
      // Writes offered during WAIT must be ignored.
      wr_valid = (i == 0); wr_addr = 3'd6; wr_data = 12'h666;
      tick();
      if (upd) uc++;
    end
    wr_valid = 0;
    n_total++; if (uc !== 0) $display("FAIL busy_no_early_upd got=%0d exp=0", uc); else n_pass++;
    ch_busy = 1; tick(); ch_busy = 0;
    n_total++; if (state !== 2'd2) $display("FAIL busy_still_wait got=%0d exp=2", state); else n_pass++;
    wait_upd(1'b0, k);
    n_total++; if (k !== 17) $display("FAIL busy_restart_latency got=%0d exp=17", k); else n_pass++;
    n_total++; if (tap_of(tap_bus, 3) !== 12'h123) $display("FAIL busy_tap3 got=%h exp=123", tap_of(tap_bus, 3)); else n_pass++;
    n_total++; if (tap_of(tap_bus, 6) !== 12'h000) $display("FAIL wait_write_ignored got=%h exp=000", tap_of(tap_bus, 6)); else n_pass++;
    n_total++; if (tap_of(tap_bus, 1) !== 12'h0F0) $display("FAIL shadow_persist got=%h exp=0F0", tap_of(tap_bus, 1)); else n_pass++;
  endtask

  task automatic test_abort_reset();
    int k;
    int uc;
    wr_valid = 1; wr_addr = 3'd4; wr_data = 12'h055; tick();
    wr_valid = 0; commit = 1; tick(); commit = 0;
    for (int i = 0; i < 8; i++) tick();
    abort = 1; tick(); abort = 0;
    n_total++; if (state !== 2'd1) $display("FAIL abort_dirty got=%0d exp=1", state); else n_pass++;
    n_total++; if (wr_ready !== 1'b1) $display("FAIL abort_wr_ready got=%b exp=1", wr_ready); else n_pass++;
    n_total++; if (upd !== 1'b0) $display("FAIL abort_upd got=%b exp=0", upd); else n_pass++;
    n_total++; if (tap_of(tap_bus, 4) !== 12'h000) $display("FAIL abort_tap4 got=%h exp=000", tap_of(tap_bus, 4)); else n_pass++;
    commit = 1; tick(); commit = 0;
    wait_upd(1'b0, k);
    n_total++; if (k !== 17) $display("FAIL recommit_latency got=%0d exp=17", k); else n_pass++;
    n_total++; if (tap_of(tap_bus, 4) !== 12'h055) $display("FAIL recommit_tap4 got=%h exp=055", tap_of(tap_bus, 4)); else n_pass++;
    // Reset in the middle of WAIT.
    wr_valid = 1; wr_addr = 3'd5; wr_data = 12'h077; commit = 1; tick();
    wr_valid = 0; commit = 0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1; #2;
    n_total++; if (tap_bus !== 96'h400) $display("FAIL rst_wait_taps got=%h exp=%h", tap_bus, 96'h400); else n_pass++;
    n_total++; if (state !== 2'd0) $display("FAIL rst_wait_state got=%0d exp=0", state); else n_pass++;
    tick(); tick();
    rst = 0;
    uc = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (upd) uc++;
    end
    n_total++; if (uc !== 0) $display("FAIL rst_no_upd got=%0d exp=0", uc); else n_pass++;
    // The shadow bank must also be back at identity.
    wr_valid = 1; wr_addr = 3'd7; wr_data = 12'h000; commit = 1; tick();
    wr_valid = 0; commit = 0;
    wait_upd(1'b0, k);
    n_total++; if (k !== 17) $display("FAIL post_rst_latency got=%0d exp=17", k); else n_pass++;
    n_total++; if (tap_bus !== 96'h400) $display("FAIL shadow_identity got=%h exp=%h", tap_bus, 96'h400); else n_pass++;
  endtask

  task automatic test_bad_addr();
    logic [71:0] exp6;
    int k;
    s_wr_valid = 1; s_wr_addr = 3'd7; s_wr_data = 12'h3FF; tick();
    s_wr_valid = 0;
    n_total++; if (s_err !== 1'b1) $display("FAIL bad_addr_err got=%b exp=1", s_err); else n_pass++;
    n_total++; if (s_state !== 2'd1) $display("FAIL bad_addr_state got=%0d exp=1", s_state); else n_pass++;
    n_total++; if (s_tap_bus !== 72'h400) $display("FAIL bad_addr_taps got=%h exp=%h", s_tap_bus, 72'h400); else n_pass++;
    s_err_clr = 1; s_wr_valid = 1; s_wr_addr = 3'd6; s_wr_data = 12'h2AA; tick();
    s_wr_valid = 0;
    n_total++; if (s_err !== 1'b1) $display("FAIL err_set_wins got=%b exp=1", s_err); else n_pass++;
    tick(); s_err_clr = 0;
    n_total++; if (s_err !== 1'b0) $display("FAIL err_clr got=%b exp=0", s_err); else n_pass++;
    s_wr_valid = 1; s_wr_addr = 3'd5; s_wr_data = 12'h111; tick();
    s_wr_valid = 0;
    n_total++; if (s_err !== 1'b0) $display("FAIL last_addr_ok got=%b exp=0", s_err); else n_pass++;
    s_commit = 1; tick(); s_commit = 0;
    wait_upd(1'b1, k);
    n_total++; if (k !== 17) $display("FAIL bad_addr_latency got=%0d exp=17", k); else n_pass++;
    exp6 = 72'h400; exp6[71:60] = 12'h111;
    n_total++; if (s_tap_bus !== exp6) $display("FAIL bad_data_dropped got=%h exp=%h", s_tap_bus, exp6); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_commit_latency();
`ifdef CH_CFG_READBACK_EN
    test_readback();
`endif
    test_busy_restart();
    test_abort_reset();
    test_bad_addr();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
